// File: rtl/seg_text_display_pkg.sv
// Shared constants for the seven-segment text display.
// Segment bit order and text width of ProgramOutput.seg.
package seg_text_display_pkg;

  localparam int SEG_TEXT_W = 64;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [SEG_TEXT_W-1:0] SEG_SPACES = {8{8'h20}};

  typedef logic [7:0] seg_t;

  function automatic logic [7:0] to_upper(input logic [7:0] ch);
    return (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
  endfunction

endpackage

// File: rtl/seg_text_display_ascii_to_seg.sv
// ASCII to seven-segment glyph decoder, {a,b,c,d,e,f,g,dp}.
// Case-insensitive; unsupported codes decode to blank.
module ascii_to_seg
  import seg_text_display_pkg::*;
(
  input  logic [7:0] i_ascii,
  output seg_t       o_seg
);

  logic [7:0] w_up;

  assign w_up = to_upper(i_ascii);

  always_comb begin
    o_seg = '0;
    case (w_up)
      "0": o_seg = 8'b1111_1100;
      "1": o_seg = 8'b0110_0000;
      "2": o_seg = 8'b1101_1010;
      "3": o_seg = 8'b1111_0010;
      "4": o_seg = 8'b0110_0110;
      "5": o_seg = 8'b1011_0110;
      "6": o_seg = 8'b1011_1110;
      "7": o_seg = 8'b1110_0000;
      "8": o_seg = 8'b1111_1110;
      "9": o_seg = 8'b1111_0110;
      "A": o_seg = 8'b1110_1110;
      "B": o_seg = 8'b0011_1110;
      "C": o_seg = 8'b1001_1100;
      "D": o_seg = 8'b0111_1010;
      "E": o_seg = 8'b1001_1110;
      "F": o_seg = 8'b1000_1110;
      "G": o_seg = 8'b1011_1100;
      "H": o_seg = 8'b0110_1110;
      "I": o_seg = 8'b0110_0000;
      "J": o_seg = 8'b0111_0000;
      "L": o_seg = 8'b0001_1100;
      "N": o_seg = 8'b0010_1010;
      "O": o_seg = 8'b1111_1100;
      "P": o_seg = 8'b1100_1110;
      "Q": o_seg = 8'b1110_0110;
      "R": o_seg = 8'b0000_1010;
      "S": o_seg = 8'b1011_0110;
      "T": o_seg = 8'b0001_1110;
      "U": o_seg = 8'b0111_1100;
      "Y": o_seg = 8'b0111_0110;
      "Z": o_seg = 8'b1101_1010;
      "-": o_seg = 8'(1 << SEG_G);
      "_": o_seg = 8'(1 << SEG_D);
      ".": o_seg = 8'(1 << SEG_DP);
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/seg_text_display.sv
// 8-digit multiplexed seven-segment text display with
// frame-aligned text latching and per-digit blinking.
module seg_text_display
  import seg_text_display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  prog_clk,
  input  logic                  rst,
  input  logic [SEG_TEXT_W-1:0] seg_text,
  input  logic [7:0]            blink_mask,
  output logic [7:0]            digit_en,
  output logic [7:0]            seg_left,
  output logic [7:0]            seg_right,
  output logic                  frame_done
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [2:0]            r_idx;
  logic [SEG_TEXT_W-1:0] r_shadow_text;
  logic [7:0]            r_shadow_mask;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_load_pending;
  logic [7:0]            r_digit_en;
  logic [7:0]            r_seg_left;
  logic [7:0]            r_seg_right;
  logic                  r_frame_done;

  logic                  w_div_wrap;
  logic                  w_frame_end;
  logic [SEG_TEXT_W-1:0] w_text;
  logic [7:0]            w_mask;
  logic [2:0]            w_pos;
  logic [7:0]            w_char;
  seg_t                  w_raw;
  seg_t                  w_glyph;

  assign w_div_wrap  = (r_div_cnt == DIV_MAX);
  assign w_frame_end = w_div_wrap && (r_idx == 3'd7);

  // Bypass the shadows on the load cycle so digit 7 is valid at once
  assign w_text = r_load_pending ? seg_text : r_shadow_text;
  assign w_mask = r_load_pending ? blink_mask : r_shadow_mask;

  assign w_pos  = 3'd7 - r_idx;
  assign w_char = w_text[{w_pos, 3'b000} +: 8];

  ascii_to_seg u_dec (
    .i_ascii (w_char),
    .o_seg   (w_raw)
  );

  assign w_glyph = (w_mask[w_pos] && r_blink_phase) ? '0 : w_raw;

  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_div_cnt      <= '0;
      r_idx          <= '0;
      r_shadow_text  <= SEG_SPACES;
      r_shadow_mask  <= '0;
      r_blink_cnt    <= '0;
      r_blink_phase  <= 1'b0;
      r_load_pending <= 1'b1;
      r_digit_en     <= '0;
      r_seg_left     <= '0;
      r_seg_right    <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_div_cnt      <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      r_load_pending <= 1'b0;
      if (w_div_wrap) begin
        r_idx <= r_idx + 3'd1;
      end
      if (r_load_pending || w_frame_end) begin
        r_shadow_text <= seg_text;
        r_shadow_mask <= blink_mask;
      end
      if (w_frame_end) begin
        if (r_blink_cnt == BLK_MAX) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      r_digit_en   <= 8'h80 >> r_idx;
      r_seg_left   <= r_idx[2] ? '0 : w_glyph;
      r_seg_right  <= r_idx[2] ? w_glyph : '0;
      r_frame_done <= w_frame_end;
    end
  end

  assign digit_en   = r_digit_en;
  assign seg_left   = r_seg_left;
  assign seg_right  = r_seg_right;
  assign frame_done = r_frame_done;

endmodule
